// File: rtl/fp_div_sched_pkg.sv
// Shared types and constants for the FP64 divider scheduler.
package fp_div_sched_pkg;

    typedef logic [63:0] fp64_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LO,
        WAIT_HI,
        RESP
    } fp_div_sched_state_t;

    // Default quiet NaN: sign 0, exponent all ones, fraction MSB set.
    localparam fp64_t FP64_QNAN_DEFAULT = 64'h7FF8_0000_0000_0000;

endpackage

// File: rtl/fp_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
// The pointer itself lives in the parent so it only advances on a real grant.
module fp_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    always_comb begin
        int  pos;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos = (int'(ptr) + i) % NREQ;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/fp_div_sched.sv
// Round-robin scheduler sharing one multi-cycle FP64 divider among NREQ requesters.
// Optional watchdog abort: define FP_DIV_SCHED_WDOG_EN.
//
// state   | meaning
// IDLE    | waiting for any req_valid; grants and latches operands
// ISSUE   | div_ld pulse to the divider
// WAIT_LO | waiting for div_done to drop (stale done ignored)
// WAIT_HI | waiting for div_done to rise; captures div_o
// RESP    | resp_valid held until resp_ready
module fp_div_sched
    import fp_div_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0][63:0] req_a,
    input  logic [NREQ-1:0][63:0] req_b,
    input  logic [NREQ-1:0][2:0] req_rm,
    output logic                 div_ld,
    output logic [63:0]          div_a,
    output logic [63:0]          div_b,
    output logic [2:0]           div_rm,
    input  logic [63:0]          div_o,
    input  logic                 div_done,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [63:0]          resp_o,
    output logic                 resp_err,
    output logic                 busy
);

    if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || TIMEOUT < 1) begin : g_bad_params
        $error("fp_div_sched: invalid parameter combination");
    end

    fp_div_sched_state_t state;
    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      cur_id;
    logic [NREQ-1:0]     grant;
    logic [IDW-1:0]      grant_idx;
    logic                wdog_expired;

    fp_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Handshake pulses are gated so a held ce or a reset cycle never grants or loads.
    assign req_ready = (ce && !rst && state == IDLE) ? grant : '0;
    assign div_ld    = ce && !rst && (state == ISSUE);
    assign busy      = (state != IDLE);

`ifdef FP_DIV_SCHED_WDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wdog_cnt;

    assign wdog_expired = (state == WAIT_LO || state == WAIT_HI) && (wdog_cnt == '0);

    // Loaded with TIMEOUT-1 on ISSUE so the abort lands on the TIMEOUT-th wait cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if (ce) begin
            if (state == ISSUE) begin
                wdog_cnt <= CW'(TIMEOUT - 1);
            end else if ((state == WAIT_LO || state == WAIT_HI) && !wdog_expired) begin
                wdog_cnt <= wdog_cnt - 1'b1;
            end
        end
    end
`else
    assign wdog_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cur_id     <= '0;
            div_a      <= '0;
            div_b      <= '0;
            div_rm     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_o     <= '0;
            resp_err   <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        div_a  <= req_a[grant_idx];
                        div_b  <= req_b[grant_idx];
                        div_rm <= req_rm[grant_idx];
                        cur_id <= grant_idx;
                        rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT_LO;
                WAIT_LO: begin
                    if (wdog_expired) begin
                        resp_o     <= FP64_QNAN_DEFAULT;
                        resp_err   <= 1'b1;
                        resp_id    <= cur_id;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (!div_done) begin
                        state <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (div_done) begin
                        resp_o     <= div_o;
                        resp_err   <= 1'b0;
                        resp_id    <= cur_id;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (wdog_expired) begin
                        resp_o     <= FP64_QNAN_DEFAULT;
                        resp_err   <= 1'b1;
                        resp_id    <= cur_id;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_sched.sv
// Scoreboard bench for fp_div_sched with a behavioural divider stub.
module tb_fp_div_sched;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  ce;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][63:0] req_a;
    logic [NREQ-1:0][63:0] req_b;
    logic [NREQ-1:0][2:0]  req_rm;
    logic                  div_ld;
    logic [63:0]           div_a, div_b, div_o;
    logic [2:0]            div_rm;
    logic                  div_done;
    logic                  resp_valid, resp_ready, resp_err, busy;
    logic [IDW-1:0]        resp_id;
    logic [63:0]           resp_o;

    fp_div_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
        .div_ld(div_ld), .div_a(div_a), .div_b(div_b), .div_rm(div_rm),
        .div_o(div_o), .div_done(div_done),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_o(resp_o), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [63:0] o;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    grant_log[$];
    int    compared   = 0;
    int    mismatched = 0;

    function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) / $bitstoreal(b));
    endfunction

    function automatic logic [63:0] rand_fp();
        logic [63:0] v;
        v[63]    = 1'($urandom_range(0, 1));
        v[62:52] = 11'($urandom_range(900, 1150));
        v[51:32] = 20'($urandom);
        v[31:0]  = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Divider stub: done stays high for 'stale' cycles after ld, low for 'lat' cycles, then high with result.
    int          cfg_stale = 0;
    int          cfg_lat   = 3;
    logic        stub_hang = 1'b0;
    logic        stub_run  = 1'b0;
    int          stub_age  = 0;
    int          stub_stale = 0;
    int          stub_lat  = 1;
    logic [63:0] stub_res  = '0;

    always @(posedge clk) begin
        if (div_ld) begin
            stub_run   <= 1'b1;
            stub_age   <= 0;
            stub_stale <= cfg_stale;
            stub_lat   <= cfg_lat;
            stub_res   <= ref_div(div_a, div_b);
        end else if (stub_run && stub_age < 100000) begin
            stub_age <= stub_age + 1;
        end
    end

    assign div_done = !stub_run ? 1'b1 :
                      (stub_age < stub_stale) ? 1'b1 :
                      (stub_hang || stub_age < stub_stale + stub_lat) ? 1'b0 : 1'b1;
    assign div_o    = (stub_run && !stub_hang && stub_age >= stub_stale + stub_lat) ?
                      stub_res : 64'hBAD0_BAD0_BAD0_BAD0;

    // Monitor / reference model state
    int              cyc = 0;
    int              m_ptr = 0;
    logic            m_in_flight = 1'b0;
    logic            m_ld_due = 1'b0;
    logic            m_resp_shown = 1'b0;
    logic [63:0]     m_op_a = '0, m_op_b = '0;
    logic [2:0]      m_op_rm = '0;
    logic [IDW-1:0]  m_hold_id = '0;
    logic [63:0]     m_hold_o = '0;
    logic            m_hold_err = 1'b0;
    int              m_ld_cycle = 0, m_resp_cycle = 0;
    int              ld_count = 0;
    int              last_id = 0;
    logic [63:0]     last_o = '0;
    logic            last_err = 1'b0;
    logic [NREQ-1:0] g_flag = '0;

    always @(negedge clk) begin
        int    g;
        resp_t e;
        cyc++;
        if (rst) begin
            exp_q.delete();
            m_ptr        = 0;
            m_in_flight  = 1'b0;
            m_ld_due     = 1'b0;
            m_resp_shown = 1'b0;
        end else begin
            if (ce && !m_in_flight && (req_valid != '0)) begin
                g = -1;
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                chk("grant", 64'(req_ready), 64'(1) << g);
                e.id = g;
                if (stub_hang) begin
                    e.o   = 64'h7FF8_0000_0000_0000;
                    e.err = 1'b1;
                end else begin
                    e.o   = ref_div(req_a[g], req_b[g]);
                    e.err = 1'b0;
                end
                exp_q.push_back(e);
                grant_log.push_back(g);
                g_flag[g]   = 1'b1;
                m_ptr       = (g + 1) % NREQ;
                m_in_flight = 1'b1;
                m_ld_due    = 1'b1;
                m_op_a      = req_a[g];
                m_op_b      = req_b[g];
                m_op_rm     = req_rm[g];
            end else begin
                chk("no_grant", 64'(req_ready), 64'(0));
            end
            if (!ce) chk("ld_gated", 64'(div_ld), 64'(0));
            if (div_ld) begin
                chk("ld_expected", 64'(m_ld_due), 64'(1));
                chk("div_a", div_a, m_op_a);
                chk("div_b", div_b, m_op_b);
                chk("div_rm", 64'(div_rm), 64'(m_op_rm));
                m_ld_due   = 1'b0;
                ld_count++;
                m_ld_cycle = cyc;
            end
            if (resp_valid) begin
                if (!m_resp_shown) begin
                    if (exp_q.size() == 0) begin
                        chk("resp_unexpected", 64'(resp_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_id", 64'(resp_id), 64'(e.id));
                        chk("resp_o", resp_o, e.o);
                        chk("resp_err", 64'(resp_err), 64'(e.err));
                    end
                    m_resp_shown = 1'b1;
                    m_hold_id    = resp_id;
                    m_hold_o     = resp_o;
                    m_hold_err   = resp_err;
                    m_resp_cycle = cyc;
                    last_id      = int'(resp_id);
                    last_o       = resp_o;
                    last_err     = resp_err;
                end else begin
                    chk("hold_id", 64'(resp_id), 64'(m_hold_id));
                    chk("hold_o", resp_o, m_hold_o);
                    chk("hold_err", 64'(resp_err), 64'(m_hold_err));
                end
                if (resp_ready && ce) begin
                    m_resp_shown = 1'b0;
                    m_in_flight  = 1'b0;
                end
            end
        end
    end

    // Stimulus
    logic auto_drop = 1'b1;

    task automatic step();
        @(posedge clk);
        #2;
        for (int i = 0; i < NREQ; i++) begin
            if (g_flag[i]) begin
                g_flag[i] = 1'b0;
                if (auto_drop) req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic issue(input int i, input logic [63:0] a, input logic [63:0] b, input logic [2:0] rm);
        req_a[i]     = a;
        req_b[i]     = b;
        req_rm[i]    = rm;
        req_valid[i] = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((m_in_flight || exp_q.size() != 0 || req_valid != '0) && n < 3000) begin
            step();
            n++;
        end
        chk(name, 64'(n < 3000), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_div_ld"}, 64'(div_ld), 64'(0));
        chk({tag, "_div_a"}, div_a, 64'(0));
        chk({tag, "_div_b"}, div_b, 64'(0));
        chk({tag, "_div_rm"}, 64'(div_rm), 64'(0));
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
        chk({tag, "_resp_id"}, 64'(resp_id), 64'(0));
        chk({tag, "_resp_o"}, resp_o, 64'(0));
        chk({tag, "_resp_err"}, 64'(resp_err), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        #600000;
        mismatched++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] a, b;
        int ld0, gl0, n;
        int exp_order[5];
        rst = 1'b1; ce = 1'b1; resp_ready = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_rm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        rst = 1'b0;

        // Directed 2.0 / 1.0 from requester 0
        ld0 = ld_count;
        issue(0, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 3'($urandom_range(0, 4)));
        drain("t1_drain");
        chk("t1_ld_count", 64'(ld_count - ld0), 64'(1));
        chk("t1_resp_id", 64'(last_id), 64'(0));
        chk("t1_resp_o", last_o, 64'h4000_0000_0000_0000);

        // All requesters valid continuously from reset
        rst = 1'b1;
        auto_drop = 1'b0;
        for (int i = 0; i < NREQ; i++) issue(i, rand_fp(), rand_fp(), 3'($urandom_range(0, 4)));
        step(); step();
        grant_log.delete();
        rst = 1'b0;
        n = 0;
        while (grant_log.size() < 5 && n < 500) begin step(); n++; end
        chk("t2_grants_seen", 64'(grant_log.size() >= 5), 64'(1));
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++)
            if (i < grant_log.size()) chk("t2_grant_order", 64'(grant_log[i]), 64'(exp_order[i]));

        // Consumer stalls for 10 cycles with all requesters still asking
        resp_ready = 1'b0;
        n = 0;
        while (!resp_valid && n < 200) begin step(); n++; end
        chk("t3_resp_seen", 64'(resp_valid), 64'(1));
        ld0 = ld_count;
        gl0 = grant_log.size();
        repeat (10) step();
        chk("t3_no_ld", 64'(ld_count - ld0), 64'(0));
        chk("t3_no_grant", 64'(grant_log.size() - gl0), 64'(0));
        chk("t3_still_valid", 64'(resp_valid), 64'(1));
        resp_ready = 1'b1;
        auto_drop = 1'b1;
        req_valid = '0;
        drain("t3_drain");

        // Stale done high for 3 cycles after ld
        cfg_stale = 3; cfg_lat = 4;
        a = rand_fp(); b = rand_fp();
        issue(1, a, b, 3'd2);
        drain("t4_drain");
        chk("t4_resp_o", last_o, ref_div(a, b));
        chk("t4_resp_id", 64'(last_id), 64'(1));

        // Reset while waiting for done, then a fresh op
        cfg_stale = 0; cfg_lat = 20;
        issue(2, rand_fp(), rand_fp(), 3'd1);
        n = 0;
        while (!(busy && !div_done && !div_ld) && n < 100) begin step(); n++; end
        repeat (3) step();
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("t5_reset");
        step();
        rst = 1'b0;
        cfg_lat = 5;
        a = rand_fp(); b = rand_fp();
        issue(3, a, b, 3'd3);
        drain("t5_drain");
        chk("t5_resp_o", last_o, ref_div(a, b));
        chk("t5_resp_id", 64'(last_id), 64'(3));

        // Randomised traffic
        n = 0;
        gl0 = grant_log.size();
        while (grant_log.size() - gl0 < 80 && n < 8000) begin
            step();
            n++;
            ce         = ($urandom_range(0, 9) != 0);
            resp_ready = ($urandom_range(0, 9) < 7);
            cfg_stale  = $urandom_range(0, 3);
            cfg_lat    = $urandom_range(1, 8);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0)
                    issue(i, rand_fp(), rand_fp(), 3'($urandom_range(0, 4)));
                else if (req_valid[i] && $urandom_range(0, 29) == 0)
                    req_valid[i] = 1'b0;
            end
        end
        chk("rand_progress", 64'(grant_log.size() - gl0 >= 80), 64'(1));
        ce = 1'b1;
        resp_ready = 1'b1;
        req_valid = '0;
        drain("rand_drain");

`ifdef FP_DIV_SCHED_WDOG_EN
        // Divider never completes: watchdog abort after TIMEOUT wait cycles
        stub_hang = 1'b1;
        issue(0, rand_fp(), rand_fp(), 3'd0);
        drain("wdog_drain");
        chk("wdog_latency", 64'(m_resp_cycle - m_ld_cycle), 64'(TIMEOUT + 1));
        chk("wdog_o", last_o, 64'h7FF8_0000_0000_0000);
        chk("wdog_err", 64'(last_err), 64'(1));
        stub_hang = 1'b0;
        step();
`endif

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
